// File: rtl/expand_if.sv
// Source-read / destination-write bus of the nearest-neighbour up-sampler.
// The master modport is the up-sampler; the slave side owns both RAMs.
interface expand_if #(
   parameter int BPP   = 3,
   parameter int RD_AW = 10,
   parameter int WR_AW = 10
);
   logic               start;
   logic [8*BPP-1:0]   pixel_in;
   logic               rd_en;
   logic [RD_AW-1:0]   rd_adrr;
   logic [8*BPP-1:0]   pixel_out;
   logic               wr_en;
   logic [WR_AW-1:0]   wr_adrr;
   logic               done;

   modport master (
      input  start,
      input  pixel_in,
      output rd_en,
      output rd_adrr,
      output pixel_out,
      output wr_en,
      output wr_adrr,
      output done
   );

   modport slave (
      output start,
      output pixel_in,
      input  rd_en,
      input  rd_adrr,
      input  pixel_out,
      input  wr_en,
      input  wr_adrr,
      input  done
   );
endinterface

// File: rtl/expand.sv
// Nearest-neighbour up-sampler: replicates each source pixel FACTOR x FACTOR, one output per clock.
// Optional EXPAND_READ_REUSE_EN: read each source pixel once per output row and replay it from a hold register.
module expand #(
   parameter int FACTOR = 2,
   parameter int BPP    = 3,
   parameter int SRC_H  = 15,
   parameter int SRC_W  = 15,
   parameter int RD_AW  = 10,
   parameter int WR_AW  = 10
) (
   input  logic      clk,
   input  logic      rst,
   expand_if.master  bus
);

   localparam int FW = (FACTOR > 1) ? $clog2(FACTOR) : 1;
   localparam int XW = (SRC_W  > 1) ? $clog2(SRC_W)  : 1;
   localparam int YW = (SRC_H  > 1) ? $clog2(SRC_H)  : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t             state;
   logic [FW-1:0]      ox_sub, oy_sub, nxt_ox, nxt_oy;
   logic [XW-1:0]      sx, nxt_sx;
   logic [YW-1:0]      sy, nxt_sy;
   logic [RD_AW-1:0]   row_base, nxt_row_base, nxt_addr;
   logic               last_pix;
   logic               drain_cnt;
   logic               issue;
   logic               issue_d;
   logic [WR_AW-1:0]   wr_cnt;
`ifdef EXPAND_READ_REUSE_EN
   logic               rd_d;
   logic [8*BPP-1:0]   hold;
`endif

   // Counter chain ox_sub -> sx -> oy_sub -> sy; row_base only moves when a whole
   // source row has been emitted FACTOR times, so rows are re-read without a divider.
   always_comb begin
      nxt_ox       = ox_sub;
      nxt_sx       = sx;
      nxt_oy       = oy_sub;
      nxt_sy       = sy;
      nxt_row_base = row_base;
      if (ox_sub == FW'(FACTOR - 1)) begin
         nxt_ox = '0;
         if (sx == XW'(SRC_W - 1)) begin
            nxt_sx = '0;
            if (oy_sub == FW'(FACTOR - 1)) begin
               nxt_oy       = '0;
               nxt_sy       = sy + 1'b1;
               nxt_row_base = row_base + RD_AW'(SRC_W);
            end else begin
               nxt_oy = oy_sub + 1'b1;
            end
         end else begin
            nxt_sx = sx + 1'b1;
         end
      end else begin
         nxt_ox = ox_sub + 1'b1;
      end
      nxt_addr = nxt_row_base + RD_AW'(nxt_sx);
      last_pix = (ox_sub == FW'(FACTOR - 1)) && (sx == XW'(SRC_W - 1)) &&
                 (oy_sub == FW'(FACTOR - 1)) && (sy == YW'(SRC_H - 1));
   end

   // Frame sequencer; the counters describe the pixel currently on rd_adrr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bus.done    <= 1'b1;
         bus.rd_en   <= 1'b0;
         bus.rd_adrr <= '0;
         ox_sub      <= '0;
         sx          <= '0;
         oy_sub      <= '0;
         sy          <= '0;
         row_base    <= '0;
         drain_cnt   <= 1'b0;
         issue       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.rd_en <= 1'b0;
               issue     <= 1'b0;
               if (bus.start) begin
                  state       <= RUN;
                  bus.done    <= 1'b0;
                  bus.rd_en   <= 1'b1;
                  bus.rd_adrr <= '0;
                  issue       <= 1'b1;
                  ox_sub      <= '0;
                  sx          <= '0;
                  oy_sub      <= '0;
                  sy          <= '0;
                  row_base    <= '0;
               end
            end
            RUN: begin
               if (last_pix) begin
                  state     <= DRAIN;
                  bus.rd_en <= 1'b0;
                  issue     <= 1'b0;
                  drain_cnt <= 1'b0;
               end else begin
                  ox_sub      <= nxt_ox;
                  sx          <= nxt_sx;
                  oy_sub      <= nxt_oy;
                  sy          <= nxt_sy;
                  row_base    <= nxt_row_base;
                  bus.rd_adrr <= nxt_addr;
`ifdef EXPAND_READ_REUSE_EN
                  bus.rd_en   <= (nxt_ox == '0);
`else
                  bus.rd_en   <= 1'b1;
`endif
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state    <= IDLE;
                  bus.done <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-stage write pipeline: RAM latency, then the registered write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_d       <= 1'b0;
         bus.wr_en     <= 1'b0;
         bus.wr_adrr   <= '0;
         bus.pixel_out <= '0;
         wr_cnt        <= '0;
`ifdef EXPAND_READ_REUSE_EN
         rd_d          <= 1'b0;
         hold          <= '0;
`endif
      end else begin
         issue_d   <= issue;
         bus.wr_en <= issue_d;
`ifdef EXPAND_READ_REUSE_EN
         rd_d      <= bus.rd_en;
`endif
         if (issue_d) begin
            bus.wr_adrr <= wr_cnt;
            wr_cnt      <= wr_cnt + 1'b1;
`ifdef EXPAND_READ_REUSE_EN
            if (rd_d) begin
               bus.pixel_out <= bus.pixel_in;
               hold          <= bus.pixel_in;
            end else begin
               bus.pixel_out <= hold;
            end
`else
            bus.pixel_out <= bus.pixel_in;
`endif
         end else if (state == IDLE) begin
            wr_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_expand.sv
// Scoreboard bench for expand: a 15x15 x2 instance and a 4x4 x3 instance,
// each fed by a source RAM model whose word at address a is {a[7:0],a[7:0],a[7:0]}.
module tb_expand;

   localparam int N_A = 900;
   localparam int N_B = 144;
`ifdef EXPAND_READ_REUSE_EN
   localparam int READS_B = 48;
`else
   localparam int READS_B = 144;
`endif

   typedef struct {
      int          adr;
      logic [23:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   writesA = 0;
   int   writesB = 0;
   int   readsB = 0;
   int   tStart = 0;
   wr_t  qA[$];
   wr_t  qB[$];
   logic [23:0] memA [0:N_A-1];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   expand_if #(.BPP(3), .RD_AW(10), .WR_AW(10)) busA ();
   expand_if #(.BPP(3), .RD_AW(10), .WR_AW(10)) busB ();

   expand #(.FACTOR(2), .BPP(3), .SRC_H(15), .SRC_W(15), .RD_AW(10), .WR_AW(10)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA.master)
   );

   expand #(.FACTOR(3), .BPP(3), .SRC_H(4), .SRC_W(4), .RD_AW(10), .WR_AW(10)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB.master)
   );

   // Source RAMs return junk when not enabled so a skipped read cannot go unnoticed.
   always @(posedge clk) begin
      busA.pixel_in <= busA.rd_en ? {3{busA.rd_adrr[7:0]}} : 24'h123456;
      busB.pixel_in <= busB.rd_en ? {3{busB.rd_adrr[7:0]}} : 24'h123456;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic pushFrame(input bit which);
      int f, h, w, src;
      wr_t e;
      f = which ? 3 : 2;
      h = which ? 4 : 15;
      w = which ? 4 : 15;
      for (int oy = 0; oy < h*f; oy++) begin
         for (int ox = 0; ox < w*f; ox++) begin
            src    = (oy/f)*w + ox/f;
            e.adr  = oy*w*f + ox;
            e.data = {3{src[7:0]}};
            if (which) qB.push_back(e);
            else       qA.push_back(e);
         end
      end
   endtask

   // Pulses start for one edge; afterwards tStart holds the index of that edge.
   task automatic applyStimulus(input bit which);
      pushFrame(which);
      @(negedge clk);
      if (which) busB.start = 1'b1;
      else       busA.start = 1'b1;
      @(posedge clk);
      #1;
      tStart = cyc;
      busA.start = 1'b0;
      busB.start = 1'b0;
   endtask

   task automatic waitDone(input bit which, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = which ? busB.done : busA.done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done timeout: got 0 expected 1 within %0d cycles", budget);
      end
   endtask

   // Write monitors: every write must match the head of its scoreboard queue.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && busA.wr_en) begin
         writesA++;
         if (busA.wr_adrr < 10'(N_A)) memA[busA.wr_adrr] = busA.pixel_out;
         if (qA.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL A unexpected write: got adr %0d expected none", busA.wr_adrr);
         end else begin
            e = qA.pop_front();
            checkOutput("A wr_adrr", 32'(busA.wr_adrr), e.adr);
            checkOutput("A pixel_out", 32'(busA.pixel_out), 32'(e.data));
         end
      end
      if (!rst && busB.rd_en) readsB++;
      if (!rst && busB.wr_en) begin
         writesB++;
         if (qB.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL B unexpected write: got adr %0d expected none", busB.wr_adrr);
         end else begin
            e = qB.pop_front();
            checkOutput("B wr_adrr", 32'(busB.wr_adrr), e.adr);
            checkOutput("B pixel_out", 32'(busB.pixel_out), 32'(e.data));
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base, exp_adr;
      busA.start = 1'b0;
      busB.start = 1'b0;

      // Idle after reset with start low.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset done", 32'(busA.done), 1);
      checkOutput("reset wr_en", 32'(busA.wr_en), 0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("idle done", 32'(busA.done), 1);
      checkOutput("idle wr_en", 32'(busA.wr_en), 0);
      checkOutput("idle rd_en", 32'(busA.rd_en), 0);
      checkOutput("idle rd_adrr", 32'(busA.rd_adrr), 0);
      checkOutput("idle wr_adrr", 32'(busA.wr_adrr), 0);
      checkOutput("idle B done", 32'(busB.done), 1);

      // Frame 1: cycle-exact read address walk over the first three output rows.
      base = writesA;
      applyStimulus(1'b0);
      for (int i = 0; i < 90; i++) begin
         exp_adr = ((i/30)/2)*15 + (i%30)/2;
         checkOutput("rd_adrr walk", 32'(busA.rd_adrr), exp_adr);
`ifdef EXPAND_READ_REUSE_EN
         checkOutput("rd_en walk", 32'(busA.rd_en), ((i%30)%2 == 0) ? 1 : 0);
`else
         checkOutput("rd_en walk", 32'(busA.rd_en), 1);
`endif
         if (i < 4) checkOutput("first wr_en", 32'(busA.wr_en), (i >= 2) ? 1 : 0);
         checkOutput("run done low", 32'(busA.done), 0);
         @(posedge clk);
         #1;
      end
      waitDone(1'b0, 2000);
      checkOutput("done latency", cyc + 1 - tStart, N_A + 3);
      checkOutput("frame1 writes", writesA - base, N_A);

      // Frame 2: start re-pulsed during RUN, then held high through completion.
      base = writesA;
      applyStimulus(1'b0);
      repeat (100) @(posedge clk);
      busA.start = 1'b1;
      @(posedge clk);
      #1;
      busA.start = 1'b0;
      repeat (780) @(posedge clk);
      #1;
      busA.start = 1'b1;
      pushFrame(1'b0);
      waitDone(1'b0, 2000);
      checkOutput("held done latency", cyc + 1 - tStart, N_A + 3);
      checkOutput("frame2 writes", writesA - base, N_A);
      base = writesA;
      @(posedge clk);
      #1;
      tStart = cyc;
      busA.start = 1'b0;
      checkOutput("restart done low", 32'(busA.done), 0);
      checkOutput("restart rd_en", 32'(busA.rd_en), 1);
      checkOutput("restart rd_adrr", 32'(busA.rd_adrr), 0);
      waitDone(1'b0, 2000);
      checkOutput("frame3 done latency", cyc + 1 - tStart, N_A + 3);
      checkOutput("frame3 writes", writesA - base, N_A);

      // Reset mid-frame around output pixel 400.
      base = writesA;
      applyStimulus(1'b0);
      for (int i = 0; i < 2000 && (writesA - base) < 400; i++) @(negedge clk);
      checkOutput("pre-reset writes", writesA - base, 400);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset wr_en", 32'(busA.wr_en), 0);
      checkOutput("async reset done", 32'(busA.done), 1);
      checkOutput("async reset rd_en", 32'(busA.rd_en), 0);
      qA.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("post-reset wr_adrr", 32'(busA.wr_adrr), 0);
      checkOutput("post-reset idle wr_en", 32'(busA.wr_en), 0);

      // Fresh full frame after reset, with hand-computed spot values.
      for (int i = 0; i < N_A; i++) memA[i] = 24'hFFFFFF;
      base = writesA;
      applyStimulus(1'b0);
      waitDone(1'b0, 2000);
      checkOutput("frame4 writes", writesA - base, N_A);
      checkOutput("mem[0]",   32'(memA[0]),   32'h000000);
      checkOutput("mem[1]",   32'(memA[1]),   32'h000000);
      checkOutput("mem[2]",   32'(memA[2]),   32'h010101);
      checkOutput("mem[31]",  32'(memA[31]),  32'h000000);
      checkOutput("mem[61]",  32'(memA[61]),  32'h0F0F0F);
      checkOutput("mem[899]", 32'(memA[899]), 32'hE0E0E0);

      // FACTOR=3, 4x4 instance: write count, read count, frame length.
      base = writesB;
      readsB = 0;
      applyStimulus(1'b1);
      waitDone(1'b1, 500);
      checkOutput("B done latency", cyc + 1 - tStart, N_B + 3);
      checkOutput("B writes", writesB - base, N_B);
      checkOutput("B reads", readsB, READS_B);

      repeat (5) @(posedge clk);
      checkOutput("A queue empty", qA.size(), 0);
      checkOutput("B queue empty", qB.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
